if_fetch_unit: RTL and testbench

Instruction fetch unit: the initiator side of the instruction-memory read port. It owns the program counter and drives the read address to the instruction memory, whose read data is registered and appears one cycle after the address is presented. It captures the returned words with their PCs into a small queue and hands them to decode with a valid/stall handshake. A redirect input handles branches and jumps by flushing everything fetched on the old path.

---
 rtl/if_fetch_unit.sv | 102 ++++++++++
 tb/tb_if_fetch_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, issues reads to a registered-output
// instruction memory and queues returned words for decode.
module if_fetch_unit #(
  parameter int ADDR_W = 8,
  parameter int ISIZE  = 16,
  parameter int QDEPTH = 2,
  parameter int CW     = $clog2(QDEPTH + 1),
  parameter int PW     = (QDEPTH > 1) ? $clog2(QDEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [ISIZE-1:0]  imem_data,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ISIZE-1:0]  inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  output logic [CW-1:0]     q_count
);

  logic [ADDR_W-1:0] fetch_pc;
  logic              inflight_v;
  logic [ADDR_W-1:0] inflight_pc;
  logic [ISIZE-1:0]  inst_q [QDEPTH];
  logic [ADDR_W-1:0] pc_q   [QDEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     count;

  logic              pop;
  logic              cap;
  logic              issue;
  logic [CW:0]       occ;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Handshake, capture and issue decisions; redirect suppresses all three.
  always_comb begin
    pop   = inst_valid & ~stall & ~redirect;
    cap   = inflight_v & ~redirect;
    occ   = {1'b0, count} + (CW+1)'(inflight_v) - (CW+1)'(pop);
    issue = ~redirect & (occ < (CW+1)'(QDEPTH));
  end

  assign imem_addr  = fetch_pc;
  assign inst_valid = (count != '0);
  assign inst       = inst_q[head];
  assign inst_pc    = pc_q[head];
  assign q_count    = count;

  // PC, in-flight read tracking and the instruction queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= '0;
      inflight_v  <= 1'b0;
      inflight_pc <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        inst_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (redirect) begin
      fetch_pc   <= redirect_pc;
      inflight_v <= 1'b0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
    end else begin
      inflight_v <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 1'b1;
      end
      if (cap) begin
        inst_q[tail] <= imem_data;
        pc_q[tail]   <= inflight_pc;
        tail         <= nxt(tail);
      end
      if (pop)
        head <= nxt(head);
      unique case ({cap, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A capture into a full queue means the issue accounting is broken.
  always @(posedge clk) begin
    if (!rst)
      assert (!(cap && count == CW'(QDEPTH)))
        else $error("fetch queue overflow on capture");
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a registered-output
// instruction memory model (word at addr a = 16'h1000 + a).
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic        stall;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic [15:0] inst;
  logic [7:0]  inst_pc;
  logic        inst_valid;
  logic [1:0]  q_count;

  int vec  = 0;
  int errs = 0;

  if_fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_valid (inst_valid),
    .q_count    (q_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) imem_data <= 16'h0;
    else     imem_data <= 16'h1000 + 16'(imem_addr);
  end

  // Leaves the bench at the negedge inside cycle 0.
  task automatic do_reset();
    rst = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 8'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 8'h0;
    repeat (2) @(negedge clk);
    vec++;
    if ({inst_valid, q_count, imem_addr} !== 11'h0) begin
      errs++;
      $display("FAIL reset_ctl got v=%b q=%0d a=%h want 0",
               inst_valid, q_count, imem_addr);
    end
    vec++;
    if ({inst, inst_pc} !== 24'h0) begin
      errs++;
      $display("FAIL reset_data got %h/%h want 0", inst, inst_pc);
    end
    rst = 1'b0;
  endtask

  task automatic test_free_run();
    do_reset();
    vec++;
    if ({inst_valid, imem_addr} !== {1'b0, 8'h00}) begin
      errs++;
      $display("FAIL fr_c0 got v=%b a=%h want 0/00", inst_valid, imem_addr);
    end
    @(negedge clk);
    vec++;
    if ({inst_valid, imem_addr} !== {1'b0, 8'h01}) begin
      errs++;
      $display("FAIL fr_c1 got v=%b a=%h want 0/01", inst_valid, imem_addr);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vec++;
      if ({inst_valid, inst_pc, inst} !== {1'b1, 8'(i), 16'h1000 + 16'(i)}) begin
        errs++;
        $display("FAIL fr_seq%0d got v=%b pc=%h i=%h want 1/%h/%h", i,
                 inst_valid, inst_pc, inst, 8'(i), 16'h1000 + 16'(i));
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    repeat (3) @(negedge clk);
    stall = 1'b1;
    for (int c = 4; c <= 8; c++) begin
      @(negedge clk);
      vec++;
      if ({q_count, imem_addr, inst_pc} !== {2'd2, 8'h03, 8'h01}) begin
        errs++;
        $display("FAIL stall_c%0d got q=%0d a=%h pc=%h want 2/03/01",
                 c, q_count, imem_addr, inst_pc);
      end
    end
    @(negedge clk);
    stall = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      vec++;
      if ({inst_valid, inst_pc, inst} !== {1'b1, 8'(i), 16'h1000 + 16'(i)}) begin
        errs++;
        $display("FAIL stall_rel%0d got v=%b pc=%h i=%h want 1/%h", i,
                 inst_valid, inst_pc, inst, 8'(i));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    repeat (5) @(negedge clk);
    vec++;
    if (inst_pc !== 8'h03) begin
      errs++;
      $display("FAIL rd_pre got pc=%h want 03", inst_pc);
    end
    redirect = 1'b1;
    redirect_pc = 8'h40;
    @(negedge clk);
    redirect = 1'b0;
    vec++;
    if ({inst_valid, imem_addr} !== {1'b0, 8'h40}) begin
      errs++;
      $display("FAIL rd_c6 got v=%b a=%h want 0/40", inst_valid, imem_addr);
    end
    @(negedge clk);
    vec++;
    if (inst_valid !== 1'b0) begin
      errs++;
      $display("FAIL rd_c7 got v=%b want 0", inst_valid);
    end
    @(negedge clk);
    vec++;
    if ({inst_valid, inst_pc, inst} !== {1'b1, 8'h40, 16'h1040}) begin
      errs++;
      $display("FAIL rd_c8 got v=%b pc=%h i=%h want 1/40/1040",
               inst_valid, inst_pc, inst);
    end
    @(negedge clk);
    vec++;
    if ({inst_valid, inst_pc} !== {1'b1, 8'h41}) begin
      errs++;
      $display("FAIL rd_c9 got v=%b pc=%h want 1/41", inst_valid, inst_pc);
    end
  endtask

  task automatic test_redirect_stall();
    do_reset();
    stall = 1'b1;
    repeat (4) @(negedge clk);
    vec++;
    if ({q_count, inst_pc} !== {2'd2, 8'h00}) begin
      errs++;
      $display("FAIL rs_full got q=%0d pc=%h want 2/00", q_count, inst_pc);
    end
    redirect = 1'b1;
    redirect_pc = 8'h20;
    @(negedge clk);
    redirect = 1'b0;
    stall = 1'b0;
    vec++;
    if ({inst_valid, q_count} !== {1'b0, 2'd0}) begin
      errs++;
      $display("FAIL rs_flush got v=%b q=%0d want 0/0", inst_valid, q_count);
    end
    @(negedge clk);
    vec++;
    if (inst_valid !== 1'b0) begin
      errs++;
      $display("FAIL rs_bub got v=%b want 0", inst_valid);
    end
    @(negedge clk);
    vec++;
    if ({inst_valid, inst_pc, inst} !== {1'b1, 8'h20, 16'h1020}) begin
      errs++;
      $display("FAIL rs_new got v=%b pc=%h i=%h want 1/20/1020",
               inst_valid, inst_pc, inst);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_pc [4];
    exp_pc[0] = 8'hFE;
    exp_pc[1] = 8'hFF;
    exp_pc[2] = 8'h00;
    exp_pc[3] = 8'h01;
    do_reset();
    redirect = 1'b1;
    redirect_pc = 8'hFE;
    repeat (3) @(negedge clk) redirect = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vec++;
      if ({inst_valid, inst_pc, inst} !==
          {1'b1, exp_pc[i], 16'h1000 + 16'(exp_pc[i])}) begin
        errs++;
        $display("FAIL wrap%0d got v=%b pc=%h i=%h want 1/%h", i,
                 inst_valid, inst_pc, inst, exp_pc[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    redirect = 1'b1;
    redirect_pc = 8'h10;
    @(negedge clk);
    redirect_pc = 8'h30;
    @(negedge clk);
    redirect = 1'b0;
    vec++;
    if ({inst_valid, imem_addr} !== {1'b0, 8'h30}) begin
      errs++;
      $display("FAIL b2b_c2 got v=%b a=%h want 0/30", inst_valid, imem_addr);
    end
    repeat (2) @(negedge clk);
    vec++;
    if ({inst_valid, inst_pc, inst} !== {1'b1, 8'h30, 16'h1030}) begin
      errs++;
      $display("FAIL b2b_c4 got v=%b pc=%h i=%h want 1/30/1030",
               inst_valid, inst_pc, inst);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    repeat (10) @(negedge clk);
    vec++;
    if ({inst_valid, inst_pc} !== {1'b1, 8'h08}) begin
      errs++;
      $display("FAIL mr_pre got v=%b pc=%h want 1/08", inst_valid, inst_pc);
    end
    rst = 1'b1;
    #1;
    vec++;
    if ({inst_valid, q_count, imem_addr, inst, inst_pc} !== 35'h0) begin
      errs++;
      $display("FAIL mr_async got v=%b q=%0d a=%h i=%h pc=%h want 0",
               inst_valid, q_count, imem_addr, inst, inst_pc);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vec++;
    if ({inst_valid, imem_addr} !== {1'b0, 8'h01}) begin
      errs++;
      $display("FAIL mr_c1 got v=%b a=%h want 0/01", inst_valid, imem_addr);
    end
    @(negedge clk);
    vec++;
    if ({inst_valid, inst_pc, inst} !== {1'b1, 8'h00, 16'h1000}) begin
      errs++;
      $display("FAIL mr_c2 got v=%b pc=%h i=%h want 1/00/1000",
               inst_valid, inst_pc, inst);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_wrap();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
